// File: rtl/dcache_pkg.sv
// Shared widths, FSM state encoding and byte-select helper for the direct-mapped data cache.
package dcache_pkg;
  localparam int TAG_W      = 3;
  localparam int INDEX_W    = 3;
  localparam int OFFSET_W   = 2;
  localparam int BLOCK_W    = 32;
  localparam int MEM_ADDR_W = 6;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WB     = 2'd1,
    FETCH  = 2'd2,
    UPDATE = 2'd3
  } dcache_state_e;

  function automatic logic [7:0] block_byte(input logic [BLOCK_W-1:0] blk,
                                            input logic [OFFSET_W-1:0] off);
    return blk[{off, 3'b000} +: 8];
  endfunction
endpackage

// File: rtl/dcache_fsm.sv
// Miss-handling FSM: write-back of a dirty victim, block fetch, line update,
// plus the CPU stall and the registered memory request signals.
module dcache_fsm
  import dcache_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req,
  input  logic                  hit,
  input  logic                  victim_dirty,
  input  logic [MEM_ADDR_W-1:0] victim_addr,
  input  logic [MEM_ADDR_W-1:0] fetch_addr,
  input  logic [BLOCK_W-1:0]    victim_data,
  input  logic                  mem_busywait,
  output logic                  busywait,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [MEM_ADDR_W-1:0] mem_address,
  output logic [BLOCK_W-1:0]    mem_writedata,
  output logic                  idle,
  output logic                  update
);
  dcache_state_e         state_r;
  dcache_state_e         next_s;
  logic                  seen_busy_r;
  logic                  done_s;
  logic                  mem_read_r;
  logic                  mem_write_r;
  logic [MEM_ADDR_W-1:0] mem_address_r;
  logic [BLOCK_W-1:0]    mem_writedata_r;

  // A transfer is finished once memory has been seen busy and then releases.
  assign done_s = seen_busy_r && !mem_busywait;

  // Next-state selection
  always_comb begin
    next_s = state_r;
    case (state_r)
      IDLE:    next_s = (req && !hit) ? (victim_dirty ? WB : FETCH) : IDLE;
      WB:      next_s = done_s ? FETCH : WB;
      FETCH:   next_s = done_s ? UPDATE : FETCH;
      UPDATE:  next_s = IDLE;
      default: next_s = IDLE;
    endcase
  end

  // State, completion tracking and memory request registers (decoded from next state)
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r         <= IDLE;
      seen_busy_r     <= 1'b0;
      mem_read_r      <= 1'b0;
      mem_write_r     <= 1'b0;
      mem_address_r   <= {MEM_ADDR_W{1'b0}};
      mem_writedata_r <= {BLOCK_W{1'b0}};
    end else begin
      state_r         <= next_s;
      seen_busy_r     <= (next_s == state_r) && (state_r == WB || state_r == FETCH) &&
                         (seen_busy_r || mem_busywait);
      mem_write_r     <= (next_s == WB);
      mem_read_r      <= (next_s == FETCH);
      mem_address_r   <= (next_s == WB)    ? victim_addr :
                         (next_s == FETCH) ? fetch_addr  : {MEM_ADDR_W{1'b0}};
      mem_writedata_r <= (next_s == WB) ? victim_data : {BLOCK_W{1'b0}};
    end
  end

  assign busywait      = (state_r != IDLE) || (req && !hit);
  assign mem_read      = mem_read_r;
  assign mem_write     = mem_write_r;
  assign mem_address   = mem_address_r;
  assign mem_writedata = mem_writedata_r;
  assign idle          = (state_r == IDLE);
  assign update        = (state_r == UPDATE);
endmodule

// File: rtl/data_cache.sv
// Direct-mapped write-back data cache between the byte-wide CPU port and block-wide memory.
// Optional hit/miss statistics counters are enabled with `define DCACHE_STATS_EN.
module data_cache
  import dcache_pkg::*;
#(
  parameter int NUM_SETS    = 8,
  parameter int BLOCK_BYTES = 4
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  READ,
  input  logic                  WRITE,
  input  logic [7:0]            ADDRESS,
  input  logic [7:0]            WRITEDATA,
  output logic [7:0]            READDATA,
  output logic                  BUSYWAIT,
  output logic                  MEM_READ,
  output logic                  MEM_WRITE,
  output logic [MEM_ADDR_W-1:0] MEM_ADDRESS,
  output logic [BLOCK_W-1:0]    MEM_WRITEDATA,
  input  logic [BLOCK_W-1:0]    MEM_READDATA,
`ifdef DCACHE_STATS_EN
  input  logic                  MEM_BUSYWAIT,
  output logic [15:0]           HIT_COUNT,
  output logic [15:0]           MISS_COUNT
`else
  input  logic                  MEM_BUSYWAIT
`endif
);
  localparam int LINE_W = BLOCK_BYTES * 8;

  logic [LINE_W-1:0]   data_mem_r [NUM_SETS];
  logic [TAG_W-1:0]    tag_mem_r  [NUM_SETS];
  logic [NUM_SETS-1:0] valid_r;
  logic [NUM_SETS-1:0] dirty_r;
  logic [7:0]          readdata_r;

  logic [TAG_W-1:0]    tag_s;
  logic [INDEX_W-1:0]  index_s;
  logic [OFFSET_W-1:0] offset_s;
  logic                req_s;
  logic                hit_s;
  logic                idle_s;
  logic                update_s;
  logic                write_hit_s;
  logic                read_hit_s;
  logic [7:0]          hit_byte_s;

  assign tag_s       = ADDRESS[7:5];
  assign index_s     = ADDRESS[4:2];
  assign offset_s    = ADDRESS[1:0];
  assign req_s       = READ || WRITE;
  assign hit_s       = valid_r[index_s] && (tag_mem_r[index_s] == tag_s);
  assign write_hit_s = idle_s && WRITE && hit_s;
  assign read_hit_s  = idle_s && READ && !WRITE && hit_s;
  assign hit_byte_s  = block_byte(data_mem_r[index_s], offset_s);

  dcache_fsm u_fsm (
    .clk          (CLK),
    .reset        (RESET),
    .req          (req_s),
    .hit          (hit_s),
    .victim_dirty (dirty_r[index_s]),
    .victim_addr  ({tag_mem_r[index_s], index_s}),
    .fetch_addr   ({tag_s, index_s}),
    .victim_data  (data_mem_r[index_s]),
    .mem_busywait (MEM_BUSYWAIT),
    .busywait     (BUSYWAIT),
    .mem_read     (MEM_READ),
    .mem_write    (MEM_WRITE),
    .mem_address  (MEM_ADDRESS),
    .mem_writedata(MEM_WRITEDATA),
    .idle         (idle_s),
    .update       (update_s)
  );

  // Data and tag arrays: line refill or single-byte store; never reset
  always_ff @(posedge CLK) begin
    if (update_s) begin
      data_mem_r[index_s] <= MEM_READDATA;
      tag_mem_r[index_s]  <= tag_s;
    end else if (write_hit_s) begin
      data_mem_r[index_s][{offset_s, 3'b000} +: 8] <= WRITEDATA;
    end
  end

  // Line status bits
  always_ff @(posedge CLK) begin
    if (RESET) begin
      valid_r <= {NUM_SETS{1'b0}};
      dirty_r <= {NUM_SETS{1'b0}};
    end else if (update_s) begin
      valid_r[index_s] <= 1'b1;
      dirty_r[index_s] <= 1'b0;
    end else if (write_hit_s) begin
      dirty_r[index_s] <= 1'b1;
    end
  end

  // Last delivered load byte, shown whenever no read hit is in progress
  always_ff @(posedge CLK) begin
    if (RESET) begin
      readdata_r <= 8'h00;
    end else if (read_hit_s) begin
      readdata_r <= hit_byte_s;
    end
  end

  assign READDATA = read_hit_s ? hit_byte_s : readdata_r;

`ifdef DCACHE_STATS_EN
  logic [15:0] hit_count_r;
  logic [15:0] miss_count_r;
  logic        pending_miss_r;

  // Saturating counters; the hit that finally retires a stalled request is not counted
  always_ff @(posedge CLK) begin
    if (RESET) begin
      hit_count_r    <= 16'h0000;
      miss_count_r   <= 16'h0000;
      pending_miss_r <= 1'b0;
    end else if (idle_s && req_s && !hit_s) begin
      miss_count_r   <= (miss_count_r == 16'hFFFF) ? miss_count_r : miss_count_r + 16'h0001;
      pending_miss_r <= 1'b1;
    end else if (idle_s && req_s && hit_s) begin
      hit_count_r    <= (pending_miss_r || hit_count_r == 16'hFFFF) ? hit_count_r
                                                                    : hit_count_r + 16'h0001;
      pending_miss_r <= 1'b0;
    end
  end

  assign HIT_COUNT  = hit_count_r;
  assign MISS_COUNT = miss_count_r;
`endif
endmodule
